pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised in-order pipeline register chain with valid/allowin handshaking, a global flush, and built-in forwarding and hazard lookup. It generalises the fixed EXE/MEM/WB segment registers into one block of STAGES identical slots. Each slot carries a result, its destination register index, a write-enable and a late-result flag. The ID stage queries the block to get bypass data or a stall request, replacing per-segment bypass wiring.

## Interface
- DATA_W, 32, width of the result payload per slot
- RDC_W, 5, width of the destination register index
- STAGES, 3, number of slots (2..8); slot 0 is youngest, slot STAGES-1 is oldest
- LATE_STAGE, 1, lowest slot index at which a late result (load, mfc0) becomes forwardable
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  discard every slot and the input beat this cycle
- in_valid  input  1  upstream has a beat
- in_allowin  output  1  chain accepts a beat this cycle
- in_data  input  DATA_W  result payload
- in_rdc  input  RDC_W  destination register index
- in_we  input  1  beat writes the register file
- in_late  input  1  payload is not final until slot LATE_STAGE
- out_valid  output  1  slot STAGES-1 holds a beat
- out_allowin  input  1  downstream accepts the oldest beat
- out_data, out_rdc, out_we  output  DATA_W/RDC_W/1  contents of slot STAGES-1
- q0_rdc, q1_rdc  input  RDC_W  source indices to look up
- q0_hit, q1_hit  output  1  a valid writing slot matches
- q0_data, q1_data  output  DATA_W  payload of the youngest matching slot
- q0_block, q1_block  output  1  youngest match is late and its slot index < LATE_STAGE
- occupancy  output  4  count of valid slots

## Operation
- Per slot i: valid_i, data_i, rdc_i, we_i, late_i.
- allowin_{STAGES-1} = !valid_{STAGES-1} || out_allowin; allowin_i = !valid_i || allowin_{i+1}; in_allowin = allowin_0.
- Slot i loads from slot i-1 (slot 0 from the input) when allowin_i. valid_i takes the upstream valid. Otherwise slot i holds.
- The input beat is accepted iff in_valid && in_allowin && !flush.
- The beat leaves slot STAGES-1 iff out_valid && out_allowin.
- flush: every valid_i clears at the next edge. Payload registers may keep stale values. flush overrides all loads that cycle.
- Match_i(q) = valid_i && we_i && rdc_i == q && q != 0. Index 0 never matches.
- hit = OR of all Match_i. data = data_j for the lowest j with a match, else 0.
- block = hit && late_j && (j < LATE_STAGE). Older matches are ignored once a younger one exists.
- Lookup is purely combinational from current slot state. It ignores the beat being presented at the input.
- occupancy = popcount(valid_*), range 0..STAGES.

## Timing
- Reset (async assert, sync release): all valid_i=0, data/rdc/we/late=0, out_valid=0, out_* payload 0, occupancy=0. in_allowin=1 and q*_hit=0 immediately.
- Latency with no backpressure: a beat accepted at edge n appears on out_* after edge n+STAGES-1, i.e. STAGES cycles input-to-output.
- Throughput is 1 beat per cycle. With full backpressure, the chain absorbs exactly STAGES beats and then deasserts in_allowin in the same cycle.
- in_allowin is combinational from out_allowin through the valid chain. There is no bubble on release: the cycle out_allowin rises, in_allowin rises if the chain is full.
- Simultaneous accept-in and drain-out on a full chain: occupancy is unchanged and every slot shifts.
- flush together with out_allowin: the oldest beat is still presented on out_* that cycle. Downstream decides whether it counts, and the block does not gate out_valid.
- Reset asserted mid-stream clears all state asynchronously, with no partial shift.

## Test plan
- Stream 6 beats (data 1..6, rdc 1..6), out_allowin=1 → out_data 1..6 on consecutive cycles, first appearing STAGES cycles after the first accept; occupancy settles at 3.
- Hold out_allowin=0, in_valid=1 → in_allowin drops after 3 accepts, occupancy=3. Raise out_allowin → the next beat is accepted that same cycle.
- Fill with rdc 5 (data 0xA) in slot 2 and rdc 5 (data 0xB) in slot 0, q0_rdc=5 → q0_hit=1, q0_data=0xB. q1_rdc=0 with a slot holding rdc 0 and we=1 → q1_hit=0, q1_data=0.
- Late beat (in_late=1, rdc 7) in slot 0, q0_rdc=7 → q0_block=1. After one shift to slot 1 → q0_block=0, q0_hit=1.
- flush asserted with the chain full and in_valid=1 → next cycle occupancy=0, out_valid=0, all q*_hit=0. The flushed input never appears at the output.
- Drop rst mid-stream for half a cycle → out_valid=0 and occupancy=0 asynchronously. Streaming resumes cleanly on the first edge after release.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain of STAGES slots with valid/allowin handshaking,
// a global flush, and a two-port forwarding/hazard lookup for the ID stage.
module pipe_stage_chain #(
    parameter int DATA_W     = 32,
    parameter int RDC_W      = 5,
    parameter int STAGES     = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RDC_W-1:0]  in_rdc,
    input  logic              in_we,
    input  logic              in_late,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [DATA_W-1:0] out_data,
    output logic [RDC_W-1:0]  out_rdc,
    output logic              out_we,
    input  logic [RDC_W-1:0]  q0_rdc,
    input  logic [RDC_W-1:0]  q1_rdc,
    output logic              q0_hit,
    output logic              q1_hit,
    output logic [DATA_W-1:0] q0_data,
    output logic [DATA_W-1:0] q1_data,
    output logic              q0_block,
    output logic              q1_block,
    output logic [3:0]        occupancy
);

    // Flat views of the slot registers; index 0 is the youngest slot.
    logic [STAGES-1:0]             slot_valid;
    logic [STAGES-1:0]             slot_we;
    logic [STAGES-1:0]             slot_late;
    logic [STAGES-1:0][DATA_W-1:0] slot_data;
    logic [STAGES-1:0][RDC_W-1:0]  slot_rdc;
    logic [STAGES-1:0]             slot_allowin;

    // What each slot would load: the input port for slot 0, the next-younger slot otherwise.
    logic [STAGES-1:0]             up_valid;
    logic [STAGES-1:0]             up_we;
    logic [STAGES-1:0]             up_late;
    logic [STAGES-1:0][DATA_W-1:0] up_data;
    logic [STAGES-1:0][RDC_W-1:0]  up_rdc;

    // Ready ripples from the oldest slot back to the input, so release has no bubble.
    always_comb begin
        slot_allowin = '0;
        slot_allowin[STAGES-1] = !slot_valid[STAGES-1] || out_allowin;
        for (int i = STAGES - 2; i >= 0; i--) begin
            slot_allowin[i] = !slot_valid[i] || slot_allowin[i+1];
        end
    end

    assign in_allowin = slot_allowin[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            logic              valid_reg;
            logic              we_reg;
            logic              late_reg;
            logic [DATA_W-1:0] data_reg;
            logic [RDC_W-1:0]  rdc_reg;

            if (gi == 0) begin : g_head
                assign up_valid[gi] = in_valid;
                assign up_we[gi]    = in_we;
                assign up_late[gi]  = in_late;
                assign up_data[gi]  = in_data;
                assign up_rdc[gi]   = in_rdc;
            end else begin : g_body
                assign up_valid[gi] = slot_valid[gi-1];
                assign up_we[gi]    = slot_we[gi-1];
                assign up_late[gi]  = slot_late[gi-1];
                assign up_data[gi]  = slot_data[gi-1];
                assign up_rdc[gi]   = slot_rdc[gi-1];
            end

            // Flush only kills the valid bits; stale payload is harmless behind valid=0.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= 1'b0;
                    we_reg    <= 1'b0;
                    late_reg  <= 1'b0;
                    data_reg  <= '0;
                    rdc_reg   <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (slot_allowin[gi]) begin
                    valid_reg <= up_valid[gi];
                    we_reg    <= up_we[gi];
                    late_reg  <= up_late[gi];
                    data_reg  <= up_data[gi];
                    rdc_reg   <= up_rdc[gi];
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_we[gi]    = we_reg;
            assign slot_late[gi]  = late_reg;
            assign slot_data[gi]  = data_reg;
            assign slot_rdc[gi]   = rdc_reg;
        end
    endgenerate

    assign out_valid = slot_valid[STAGES-1];
    assign out_data  = slot_data[STAGES-1];
    assign out_rdc   = slot_rdc[STAGES-1];
    assign out_we    = slot_we[STAGES-1];

    logic [1:0]             q_hit;
    logic [1:0]             q_block;
    logic [1:0][DATA_W-1:0] q_data;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic [RDC_W-1:0]  q_rdc;
            logic [STAGES-1:0] match;
            logic              hit;
            logic              block;
            logic [DATA_W-1:0] data;

            assign q_rdc = (gi == 0) ? q0_rdc : q1_rdc;

            // Register 0 is hard-wired zero and never needs a bypass.
            always_comb begin
                match = '0;
                for (int j = 0; j < STAGES; j++) begin
                    match[j] = slot_valid[j] && slot_we[j] &&
                               (slot_rdc[j] == q_rdc) && (q_rdc != '0);
                end
            end

            // Scan oldest to youngest so the youngest match overwrites older ones.
            always_comb begin
                hit   = 1'b0;
                block = 1'b0;
                data  = '0;
                for (int j = STAGES - 1; j >= 0; j--) begin
                    if (match[j]) begin
                        hit   = 1'b1;
                        data  = slot_data[j];
                        block = slot_late[j] && (j < LATE_STAGE);
                    end
                end
            end

            assign q_hit[gi]   = hit;
            assign q_block[gi] = block;
            assign q_data[gi]  = data;
        end
    endgenerate

    assign q0_hit   = q_hit[0];
    assign q1_hit   = q_hit[1];
    assign q0_block = q_block[0];
    assign q1_block = q_block[1];
    assign q0_data  = q_data[0];
    assign q1_data  = q_data[1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + 4'(slot_valid[i]);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (STAGES=3, LATE_STAGE=1).
module tb_pipe_stage_chain;
    localparam int DATA_W     = 32;
    localparam int RDC_W      = 5;
    localparam int STAGES     = 3;
    localparam int LATE_STAGE = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_allowin;
    logic [DATA_W-1:0] in_data = '0;
    logic [RDC_W-1:0]  in_rdc = '0;
    logic              in_we = 1'b0;
    logic              in_late = 1'b0;
    logic              out_valid;
    logic              out_allowin = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [RDC_W-1:0]  out_rdc;
    logic              out_we;
    logic [RDC_W-1:0]  q0_rdc = '0;
    logic [RDC_W-1:0]  q1_rdc = '0;
    logic              q0_hit, q1_hit, q0_block, q1_block;
    logic [DATA_W-1:0] q0_data, q1_data;
    logic [3:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_chain #(
        .DATA_W(DATA_W), .RDC_W(RDC_W), .STAGES(STAGES), .LATE_STAGE(LATE_STAGE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
        .in_rdc(in_rdc), .in_we(in_we), .in_late(in_late),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
        .out_rdc(out_rdc), .out_we(out_we),
        .q0_rdc(q0_rdc), .q1_rdc(q1_rdc),
        .q0_hit(q0_hit), .q1_hit(q1_hit),
        .q0_data(q0_data), .q1_data(q1_data),
        .q0_block(q0_block), .q1_block(q1_block),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_checks++;
        if (in_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_in_allowin: got %0b expected 1", in_allowin); end
        n_checks++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        q0_rdc = 5'd3;
        #1;
        n_checks++;
        if (q0_hit !== 1'b0) begin n_fail++; $display("FAIL reset_q0_hit: got %0b expected 0", q0_hit); end
        step();
        step();
        rst = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_stream();
        logic [3:0] exp_occ;
        logic       exp_valid;
        out_allowin = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                in_valid = 1'b1; in_we = 1'b1; in_late = 1'b0;
                in_data = 32'(c + 1); in_rdc = 5'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_allowin !== 1'b1) begin n_fail++; $display("FAIL stream_in_allowin c=%0d: got %0b expected 1", c, in_allowin); end
            step();
            exp_valid = (c >= 2) && (c <= 7);
            n_checks++;
            if (out_valid !== exp_valid) begin n_fail++; $display("FAIL stream_out_valid c=%0d: got %0b expected %0b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                n_checks++;
                if (out_data !== 32'(c - 1) || out_rdc !== 5'(c - 1)) begin
                    n_fail++; $display("FAIL stream_out_data c=%0d: got %h/%0d expected %h/%0d", c, out_data, out_rdc, c - 1, c - 1);
                end
            end
            exp_occ = 4'd0;
            for (int b = c - 2; b <= c; b++) if (b >= 0 && b < 6) exp_occ = exp_occ + 4'd1;
            n_checks++;
            if (occupancy !== exp_occ) begin n_fail++; $display("FAIL stream_occupancy c=%0d: got %0d expected %0d", c, occupancy, exp_occ); end
            $display("stream cycle %0d out_valid=%0b out_data=%h occupancy=%0d", c, out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        logic exp_allow;
        acc = 0;
        out_allowin = 1'b0;
        in_valid = 1'b1; in_we = 1'b1; in_late = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'(16 + acc); in_rdc = 5'(acc + 1);
            #1;
            exp_allow = (acc < STAGES);
            n_checks++;
            if (in_allowin !== exp_allow) begin n_fail++; $display("FAIL bp_in_allowin k=%0d: got %0b expected %0b", k, in_allowin, exp_allow); end
            step();
            if (exp_allow) acc++;
            $display("backpressure cycle %0d accepted=%0d occupancy=%0d", k, acc, occupancy);
        end
        n_checks++;
        if (occupancy !== 4'd3) begin n_fail++; $display("FAIL bp_full_occupancy: got %0d expected 3", occupancy); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h10) begin n_fail++; $display("FAIL bp_full_out: got %0b/%h expected 1/10", out_valid, out_data); end
        in_data = 32'h13; in_rdc = 5'd4;
        out_allowin = 1'b1;
        #1;
        n_checks++;
        if (in_allowin !== 1'b1) begin n_fail++; $display("FAIL bp_release_allowin: got %0b expected 1", in_allowin); end
        step();
        n_checks++;
        if (occupancy !== 4'd3) begin n_fail++; $display("FAIL bp_shift_occupancy: got %0d expected 3", occupancy); end
        n_checks++;
        if (out_data !== 32'h11) begin n_fail++; $display("FAIL bp_shift_out_data: got %h expected 11", out_data); end
        in_valid = 1'b0;
        step(); step(); step();
        n_checks++;
        if (occupancy !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got occ %0d valid %0b expected 0/0", occupancy, out_valid); end
    endtask

    task automatic test_forward();
        out_allowin = 1'b0;
        in_valid = 1'b1; in_we = 1'b1; in_late = 1'b0;
        in_rdc = 5'd5; in_data = 32'hA; step();
        in_rdc = 5'd0; in_data = 32'h55; step();
        in_rdc = 5'd5; in_data = 32'hB; step();
        in_valid = 1'b0;
        q0_rdc = 5'd5; q1_rdc = 5'd0;
        #1;
        $display("forward query q0=5 hit=%0b data=%h q1=0 hit=%0b", q0_hit, q0_data, q1_hit);
        n_checks++;
        if (q0_hit !== 1'b1 || q0_data !== 32'hB) begin n_fail++; $display("FAIL fwd_youngest: got %0b/%h expected 1/b", q0_hit, q0_data); end
        n_checks++;
        if (q0_block !== 1'b0) begin n_fail++; $display("FAIL fwd_no_block: got %0b expected 0", q0_block); end
        n_checks++;
        if (q1_hit !== 1'b0 || q1_data !== 32'h0) begin n_fail++; $display("FAIL fwd_reg0: got %0b/%h expected 0/0", q1_hit, q1_data); end
        n_checks++;
        if (out_data !== 32'hA || out_rdc !== 5'd5) begin n_fail++; $display("FAIL fwd_oldest_out: got %h/%0d expected a/5", out_data, out_rdc); end
        // A beat waiting at the input must stay invisible to the lookup.
        in_valid = 1'b1; in_rdc = 5'd9; in_data = 32'h99;
        q0_rdc = 5'd9; q1_rdc = 5'd5;
        #1;
        n_checks++;
        if (q0_hit !== 1'b0 || q0_data !== 32'h0) begin n_fail++; $display("FAIL fwd_ignore_input: got %0b/%h expected 0/0", q0_hit, q0_data); end
        n_checks++;
        if (q1_hit !== 1'b1 || q1_data !== 32'hB) begin n_fail++; $display("FAIL fwd_q1_port: got %0b/%h expected 1/b", q1_hit, q1_data); end
        in_valid = 1'b0;
        out_allowin = 1'b1;
        step(); step(); step();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL fwd_drain: got %0d expected 0", occupancy); end
    endtask

    task automatic test_late();
        out_allowin = 1'b1;
        in_valid = 1'b1; in_we = 1'b1; in_rdc = 5'd7;
        in_late = 1'b0; in_data = 32'h70; step();
        in_late = 1'b1; in_data = 32'h77; step();
        in_valid = 1'b0; in_late = 1'b0;
        q0_rdc = 5'd7; q1_rdc = 5'd7;
        #1;
        $display("late query slot0 hit=%0b block=%0b data=%h", q0_hit, q0_block, q0_data);
        n_checks++;
        if (q0_hit !== 1'b1 || q0_block !== 1'b1 || q0_data !== 32'h77) begin
            n_fail++; $display("FAIL late_slot0_block: got %0b/%0b/%h expected 1/1/77", q0_hit, q0_block, q0_data);
        end
        n_checks++;
        if (q1_block !== 1'b1) begin n_fail++; $display("FAIL late_slot0_q1_block: got %0b expected 1", q1_block); end
        step();
        $display("late query slot1 hit=%0b block=%0b data=%h", q0_hit, q0_block, q0_data);
        n_checks++;
        if (q0_hit !== 1'b1 || q0_block !== 1'b0 || q0_data !== 32'h77) begin
            n_fail++; $display("FAIL late_slot1_forward: got %0b/%0b/%h expected 1/0/77", q0_hit, q0_block, q0_data);
        end
        step(); step();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL late_drain: got %0d expected 0", occupancy); end
    endtask

    task automatic test_flush();
        out_allowin = 1'b0;
        in_valid = 1'b1; in_we = 1'b1; in_late = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'(33 + k); in_rdc = 5'(k + 1);
            step();
        end
        n_checks++;
        if (occupancy !== 4'd3) begin n_fail++; $display("FAIL flush_fill: got %0d expected 3", occupancy); end
        flush = 1'b1; in_data = 32'h99; in_rdc = 5'd4; out_allowin = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h21) begin n_fail++; $display("FAIL flush_out_presented: got %0b/%h expected 1/21", out_valid, out_data); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        q0_rdc = 5'd4; q1_rdc = 5'd1;
        #1;
        $display("flush done occupancy=%0d out_valid=%0b", occupancy, out_valid);
        n_checks++;
        if (occupancy !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got occ %0d valid %0b expected 0/0", occupancy, out_valid); end
        n_checks++;
        if (q0_hit !== 1'b0 || q1_hit !== 1'b0) begin n_fail++; $display("FAIL flush_lookup: got %0b/%0b expected 0/0", q0_hit, q1_hit); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak k=%0d: got %0b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_async_reset();
        out_allowin = 1'b1;
        in_valid = 1'b1; in_we = 1'b1; in_late = 1'b0;
        in_data = 32'h31; in_rdc = 5'd1; step();
        in_data = 32'h32; in_rdc = 5'd2; step();
        n_checks++;
        if (occupancy !== 4'd2) begin n_fail++; $display("FAIL areset_pre_occ: got %0d expected 2", occupancy); end
        q0_rdc = 5'd1;
        #1 rst = 1'b0;
        #1;
        $display("async reset asserted occupancy=%0d out_valid=%0b", occupancy, out_valid);
        n_checks++;
        if (occupancy !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_clear: got occ %0d valid %0b expected 0/0", occupancy, out_valid); end
        n_checks++;
        if (q0_hit !== 1'b0 || in_allowin !== 1'b1) begin n_fail++; $display("FAIL areset_comb: got hit %0b allowin %0b expected 0/1", q0_hit, in_allowin); end
        #4;
        in_data = 32'h33; in_rdc = 5'd3;
        rst = 1'b1;
        step();
        n_checks++;
        if (occupancy !== 4'd1) begin n_fail++; $display("FAIL areset_resume_occ: got %0d expected 1", occupancy); end
        in_valid = 1'b0;
        step(); step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin n_fail++; $display("FAIL areset_resume_out: got %0b/%h expected 1/33", out_valid, out_data); end
        step();
        n_checks++;
        if (occupancy !== 4'd0) begin n_fail++; $display("FAIL areset_drain: got %0d expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_forward();
        test_late();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
